// File: rtl/edge_interval_monitor_if.sv
// Bundle of the event inputs and measurement outputs of the edge interval monitor.
// The monitor takes the slave side; the driver and observer take the master side.
interface edge_interval_monitor_if #(
  parameter int COUNT_WIDTH = 8,
  parameter int VIOL_WIDTH  = 8
);
  logic                   enable;
  logic                   event1;
  logic                   event2;
  logic                   clear_stats;
  logic                   delay_valid;
  logic [COUNT_WIDTH-1:0] delay_value;
  logic                   min_violation;
  logic                   max_violation;
  logic                   overdue;
  logic [COUNT_WIDTH-1:0] worst_delay;
  logic [VIOL_WIDTH-1:0]  violation_count;

  modport slave (
    input  enable, event1, event2, clear_stats,
    output delay_valid, delay_value, min_violation,
    output max_violation, overdue, worst_delay,
    output violation_count
  );

  modport master (
    output enable, event1, event2, clear_stats,
    input  delay_valid, delay_value, min_violation,
    input  max_violation, overdue, worst_delay,
    input  violation_count
  );
endinterface

// File: rtl/edge_interval_monitor.sv
// Measures cycles from an event1 rising edge to the next event2 rising edge,
// flags out-of-window results and keeps worst-case and violation statistics.
module edge_interval_monitor #(
  parameter int COUNT_WIDTH = 8,
  parameter int MIN_DELAY   = 4,
  parameter int MAX_DELAY   = 10,
  parameter int VIOL_WIDTH  = 8
) (
  input logic                   clk,
  input logic                   reset,
  edge_interval_monitor_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_ARMED
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] MIN_C = COUNT_WIDTH'(MIN_DELAY);
  localparam logic [COUNT_WIDTH-1:0] MAX_C = COUNT_WIDTH'(MAX_DELAY);
  localparam logic [COUNT_WIDTH-1:0] ONE_C = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] SAT_C = '1;
  localparam logic [VIOL_WIDTH-1:0]  VSAT_C = '1;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   e1_prev_q, e1_prev_d;
  logic                   e2_prev_q, e2_prev_d;
  logic                   hist_ok_q, hist_ok_d;
  logic                   valid_q, valid_d;
  logic [COUNT_WIDTH-1:0] value_q, value_d;
  logic                   minv_q, minv_d;
  logic                   maxv_q, maxv_d;
  logic                   overdue_q, overdue_d;
  logic [COUNT_WIDTH-1:0] worst_q, worst_d;
  logic [VIOL_WIDTH-1:0]  viol_q, viol_d;

  logic                   rise1;
  logic                   rise2;
  logic                   res_vld;
  logic [COUNT_WIDTH-1:0] res_val;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic [COUNT_WIDTH-1:0] worst_base;
  logic [VIOL_WIDTH-1:0]  viol_base;

  // cnt_q holds the cycles elapsed since the start edge, so a stop edge
  // seen while cnt_q == n reports n directly.
  always_comb begin
    e1_prev_d = bus.event1;
    e2_prev_d = bus.event2;
    hist_ok_d = 1'b1;
    // The first cycle after reset only loads history, so a level that
    // was already high is not taken as an edge.
    rise1     = bus.event1 & ~e1_prev_q & hist_ok_q;
    rise2     = bus.event2 & ~e2_prev_q & hist_ok_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_vld   = 1'b0;
    res_val   = cnt_q;
    cnt_inc   = (cnt_q == SAT_C) ? cnt_q : cnt_q + ONE_C;
    if (!bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rise1 && rise2) begin
            res_vld = 1'b1;
            res_val = '0;
          end else if (rise1) begin
            state_d = S_ARMED;
            cnt_d   = ONE_C;
          end
        end
        S_ARMED: begin
          cnt_d = cnt_inc;
          if (rise2) begin
            res_vld = 1'b1;
            res_val = cnt_q;
            if (rise1) begin
              cnt_d = ONE_C;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else if (rise1) begin
            cnt_d = ONE_C;
          end
        end
      endcase
    end
  end

  always_comb begin
    overdue_d  = bus.enable && (state_q == S_ARMED)
                 && !rise1 && (cnt_q >= MAX_C);
    valid_d    = res_vld;
    value_d    = res_vld ? res_val : value_q;
    minv_d     = res_vld && (res_val < MIN_C);
    maxv_d     = res_vld && (res_val > MAX_C);
    // A clear takes effect before the same-cycle result is accumulated.
    worst_base = bus.clear_stats ? '0 : worst_q;
    viol_base  = bus.clear_stats ? '0 : viol_q;
    worst_d    = (res_vld && (res_val > worst_base)) ? res_val : worst_base;
    viol_d     = viol_base;
    if ((minv_d || maxv_d) && (viol_base != VSAT_C)) begin
      viol_d = viol_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      e1_prev_q <= 1'b0;
      e2_prev_q <= 1'b0;
      hist_ok_q <= 1'b0;
      valid_q   <= 1'b0;
      value_q   <= '0;
      minv_q    <= 1'b0;
      maxv_q    <= 1'b0;
      overdue_q <= 1'b0;
      worst_q   <= '0;
      viol_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      e1_prev_q <= e1_prev_d;
      e2_prev_q <= e2_prev_d;
      hist_ok_q <= hist_ok_d;
      valid_q   <= valid_d;
      value_q   <= value_d;
      minv_q    <= minv_d;
      maxv_q    <= maxv_d;
      overdue_q <= overdue_d;
      worst_q   <= worst_d;
      viol_q    <= viol_d;
    end
  end

  assign bus.delay_valid     = valid_q;
  assign bus.delay_value     = value_q;
  assign bus.min_violation   = minv_q;
  assign bus.max_violation   = maxv_q;
  assign bus.overdue         = overdue_q;
  assign bus.worst_delay     = worst_q;
  assign bus.violation_count = viol_q;

endmodule

// File: doc/edge_interval_monitor.md
Name: edge_interval_monitor

Overview:
- Synthesizable, clocked counterpart to the behavioural max-delay checkers.
- Measures, in clock cycles, the interval from a rising edge on event1 to the next rising edge on event2.
- Flags results outside [MIN_DELAY, MAX_DELAY] and keeps worst-case and violation statistics.
- Sits beside PLCA/PCS blocks, e.g. to check beacon-to-commit or TX_EN-to-CRS latency in hardware and in regression benches.

Parameters:
COUNT_WIDTH, 8, width of interval counter and reported values
MIN_DELAY, 4, smallest legal interval in cycles
MAX_DELAY, 10, largest legal interval in cycles; must satisfy MIN_DELAY <= MAX_DELAY <= 2^COUNT_WIDTH-2
VIOL_WIDTH, 8, width of violation counter

Ports:
clk  input  1  single clock for all logic
reset  input  1  synchronous, active-high reset
enable  input  1  monitor enable; low forces IDLE and ignores edges
event1  input  1  start event, synchronous to clk
event2  input  1  stop event, synchronous to clk
clear_stats  input  1  clears worst_delay and violation_count
delay_valid  output  1  one-cycle pulse, result available
delay_value  output  COUNT_WIDTH  measured interval, held until next result
min_violation  output  1  one-cycle pulse with delay_valid when result < MIN_DELAY
max_violation  output  1  one-cycle pulse with delay_valid when result > MAX_DELAY
overdue  output  1  level, ARMED and elapsed > MAX_DELAY
worst_delay  output  COUNT_WIDTH  largest result since reset/clear
violation_count  output  VIOL_WIDTH  saturating count of min+max violations

Behaviour:
- Reset: every output is 0; state IDLE; counter 0; edge-detect history registers 0.
  - A level already high after reset produces an edge only after it goes low then high again.
- Edge detect: rise = input & ~previous.
  - History updates every cycle, regardless of enable.
- States IDLE and ARMED. Edge detected in cycle k; event2 edge detected in cycle k+n gives result n.
- IDLE:
  - event1 rise -> ARMED, elapsed = 0.
  - event2 rise alone ignored.
  - event1 and event2 rise together -> result 0, stay IDLE.
- ARMED:
  - elapsed increments each cycle, saturating at 2^COUNT_WIDTH-1.
  - event2 rise -> result = elapsed to date (saturated) -> IDLE.
  - event1 rise alone -> restart (elapsed = 0), no result reported.
  - event1 and event2 rise together -> report the current measurement and start a new one (stay ARMED).
- Result cycle k+n -> outputs registered at k+n+1:
  - delay_valid=1, delay_value=n.
  - Violation pulses per limits.
  - worst_delay = max(worst_delay, n).
  - violation_count += 1 if either violation, saturating at all-ones.
- overdue: registered; high from cycle k+MAX_DELAY+1 while ARMED; low the cycle after the result or the leaving of ARMED.
- enable low: next cycle IDLE, overdue 0, no result; statistics retained.
- clear_stats: worst_delay and violation_count become 0 next cycle.
  - If a result is processed in the same cycle, the clear applies first and the result is then accumulated (worst=n, count=0/1).
- reset mid-measurement: abandons it, no result.

Test Plan:
- Defaults; event1 rise cycle 0, event2 rise cycle 7 -> cycle 8: delay_valid=1, delay_value=7, no violation, worst_delay=7, violation_count=0.
- event1 cycle 0, event2 cycle 12 -> overdue high cycles 11..13, then low; cycle 13: delay_value=12, max_violation=1, violation_count=1, worst_delay=12.
- event1 cycle 0, event2 cycle 2 -> delay_value=2, min_violation=1; worst_delay unchanged at prior 12; event1 and event2 rising together in IDLE -> delay_value=0, min_violation=1.
- event1 rise, no event2 for 300 cycles, then event2 -> delay_value=255 (saturated), max_violation=1, overdue high throughout from cycle 11.
- Re-arm and overlap cases:
  - event1 at 0 and 3, event2 at 9 -> single result 6, no result for the first start.
  - event1+event2 together at 5 after event1 at 0 -> result 5 and new measurement; event2 at 10 -> result 5.
- Reset and clear cases:
  - reset asserted at cycle 4 of a measurement -> all outputs 0, later event2 ignored.
  - clear_stats coincident with a result of 12 -> worst_delay=12, violation_count=1.
  - enable low mid-measurement -> no result.
